// File: rtl/s_block_writeback.sv
// -----------------------------------------------------------------------------
// s_block_writeback
//
// Last stage of the per-block IDCT loop. Reads the 64 signed 32-bit S
// accumulations of one 8x8 block from the embedded dual-port RAM. Each value
// is scaled by an arithmetic right shift, clipped to 0..255 and paired with
// its neighbour into a 16-bit word {even, odd}. The 32 resulting words are
// written into the external SRAM pixel plane at the block's raster position.
//
// Optional feature (compile-time macro):
//   WS_ROUND_EN  adds 1 << (SHIFT-1) before the shift (round-half-up).
//                Without it the shift truncates toward negative infinity.
//
// Parameters:
//   S_BASE          DPRAM address of S[0][0]; S[r][c] is at S_BASE + 8r + c
//   Y_BASE          SRAM word address of pixel (0,0) of the target plane
//   WORDS_PER_ROW   SRAM words per image row (two pixels per word)
//   SHIFT           arithmetic right shift applied to each S value
//
// Ports:
//   CLOCK_50_I       in   1   clock
//   Resetn           in   1   asynchronous active-low reset
//   WS_start         in   1   one-cycle start pulse, honoured only in IDLE
//   WS_done          out  1   one-cycle pulse after the last SRAM write
//   block_row        in   5   block row index (0..29), latched on start
//   block_col        in   6   block column index (0..39), latched on start
//   dp_address       out  7   DPRAM read address (read latency 1 cycle)
//   dp_read_data     in  32   DPRAM read data, signed two's complement
//   SRAM_address     out 18   SRAM word address (registered)
//   SRAM_write_data  out 16   packed pixels {even[7:0], odd[7:0]} (registered)
//   SRAM_we_n        out  1   SRAM write enable, active low (registered)
//
// Timing, with cycle 0 the first RUN cycle:
//   cycle n      : dp_address = S_BASE + n              (n = 0..63)
//   cycle n+1    : data for index n is on dp_read_data
//   cycle n+2    : SRAM write for odd n                 (cycles 3, 5, ..., 65)
//   cycle 66     : WS_done
//   cycle 67     : back in IDLE, a new start is accepted
// -----------------------------------------------------------------------------
module s_block_writeback #(
  parameter logic [6:0]  S_BASE        = 7'd64,
  parameter logic [17:0] Y_BASE        = 18'd0,
  parameter int          WORDS_PER_ROW = 160,
  parameter int          SHIFT         = 16
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        WS_start,
  output logic        WS_done,
  input  logic [4:0]  block_row,
  input  logic [5:0]  block_col,
  output logic [6:0]  dp_address,
  input  logic [31:0] dp_read_data,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [17:0] ROW_STRIDE = 18'(WORDS_PER_ROW);

  state_t      state;
  state_t      state_next;

  logic [5:0]  n;            // read index while in RUN
  logic        drain_cnt;    // second DRAIN cycle flag
  logic [4:0]  row_q;
  logic [5:0]  col_q;

  // Read pipeline: marks which index the current dp_read_data belongs to.
  logic        rd_valid;
  logic [5:0]  rd_idx;

  logic [7:0]  even_pix;
  logic [7:0]  pix;
  logic [17:0] pix_row;
  logic [17:0] wr_addr;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together on the edge, independent of process evaluation order.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: each signal driven here gets a default before the case statement,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    WS_done    = 1'b0;
    dp_address = '0;
    case (state)
      S_IDLE: begin
        if (WS_start) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        dp_address = S_BASE + {1'b0, n};
        if (n == 6'd63) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Two cycles: one for the last DPRAM read to return, one for the
        // final write to be registered onto the SRAM pins.
        if (drain_cnt) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        WS_done    = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read index, drain counter and latched block position
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      n         <= '0;
      drain_cnt <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
    end else begin
      if (state == S_IDLE && WS_start) begin
        n     <= '0;
        row_q <= block_row;
        col_q <= block_col;
      end else if (state == S_RUN) begin
        // Wraps 63 -> 0 on the RUN-to-DRAIN transition.
        n <= n + 6'd1;
      end
      drain_cnt <= (state == S_DRAIN) ? ~drain_cnt : 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel conversion: shift, then clip to 0..255
  // ---------------------------------------------------------------------------
`ifdef WS_ROUND_EN
  localparam int          VW         = 33;
  localparam logic [32:0] ROUND_BIAS = 33'd1 << (SHIFT - 1);

  logic [32:0]          rounded;
  logic signed [VW-1:0] v;

  // Sign-extend to 33 bits first so the bias can never overflow into the
  // sign bit for large positive accumulations.
  assign rounded = {dp_read_data[31], dp_read_data} + ROUND_BIAS;
  assign v       = $signed(rounded) >>> SHIFT;
`else
  localparam int VW = 32;

  logic signed [VW-1:0] v;

  assign v = $signed(dp_read_data) >>> SHIFT;
`endif

  always_comb begin
    if (v[VW-1]) begin
      pix = 8'd0;
    end else if (|v[VW-2:8]) begin
      pix = 8'd255;
    end else begin
      pix = v[7:0];
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM address of the pair currently completing
  // ---------------------------------------------------------------------------
  // Pair p = rd_idx >> 1: block-local row r = rd_idx[5:3], word c2 = rd_idx[2:1].
  assign pix_row = {10'd0, row_q, 3'b000} + {15'd0, rd_idx[5:3]};
  assign wr_addr = Y_BASE
                 + pix_row * ROW_STRIDE
                 + {10'd0, col_q, 2'b00}
                 + {16'd0, rd_idx[2:1]};

  // ---------------------------------------------------------------------------
  // Read pipeline, even-pixel hold and registered SRAM write port
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      rd_valid        <= 1'b0;
      rd_idx          <= '0;
      even_pix        <= '0;
      SRAM_we_n       <= 1'b1;
      SRAM_address    <= '0;
      SRAM_write_data <= '0;
    end else begin
      rd_valid  <= (state == S_RUN);
      rd_idx    <= n;
      SRAM_we_n <= 1'b1;
      if (rd_valid) begin
        if (!rd_idx[0]) begin
          even_pix <= pix;
        end else begin
          // Address and data only change with a write, so they hold their
          // last values between writes.
          SRAM_we_n       <= 1'b0;
          SRAM_address    <= wr_addr;
          SRAM_write_data <= {even_pix, pix};
        end
      end
    end
  end

endmodule

// File: tb/tb_s_block_writeback.sv
// -----------------------------------------------------------------------------
// tb_s_block_writeback
//
// Self-checking bench for s_block_writeback. A DPRAM model with one cycle of
// read latency feeds the DUT; every SRAM write, the dp_address sequence and
// the WS_done timing of each block are compared against a reference model
// built from plain integer arithmetic (floor division, clip, raster address).
// -----------------------------------------------------------------------------
module tb_s_block_writeback;

  logic        CLOCK_50_I;
  logic        Resetn;
  logic        WS_start;
  logic        WS_done;
  logic [4:0]  block_row;
  logic [5:0]  block_col;
  logic [6:0]  dp_address;
  logic [31:0] dp_read_data;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  int checks;
  int errors;

  logic [31:0] mem [128];

  localparam int MODE_RAMP  = 0;
  localparam int MODE_CONST = 1;
  localparam int MODE_RAND  = 2;

  s_block_writeback dut (
    .CLOCK_50_I      (CLOCK_50_I),
    .Resetn          (Resetn),
    .WS_start        (WS_start),
    .WS_done         (WS_done),
    .block_row       (block_row),
    .block_col       (block_col),
    .dp_address      (dp_address),
    .dp_read_data    (dp_read_data),
    .SRAM_address    (SRAM_address),
    .SRAM_write_data (SRAM_write_data),
    .SRAM_we_n       (SRAM_we_n)
  );

  initial CLOCK_50_I = 1'b0;
  always #5 CLOCK_50_I = ~CLOCK_50_I;

  // DPRAM model: synchronous read, one cycle of latency.
  always @(posedge CLOCK_50_I) begin
    dp_read_data <= mem[dp_address];
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference pixel: floor((d [+ half]) / 2^16), clipped to 0..255.
  function automatic logic [7:0] ref_pix(input logic [31:0] d);
    longint x;
    longint q;
    x = longint'($signed(d));
`ifdef WS_ROUND_EN
    x = x + 32768;
`endif
    q = x / 65536;
    if (x < 0 && q * 65536 != x) q = q - 1;
    if (q < 0) return 8'd0;
    if (q > 255) return 8'd255;
    return q[7:0];
  endfunction

  task automatic fill(input int mode, input logic [31:0] value);
    int hi;
    for (int a = 0; a < 128; a++) begin
      if (a < 64) begin
        mem[a] = $urandom;  // junk outside the S area
      end else if (mode == MODE_RAMP) begin
        mem[a] = 32'(a - 64) << 16;
      end else if (mode == MODE_CONST) begin
        mem[a] = value;
      end else if ($urandom_range(0, 7) == 0) begin
        mem[a] = $urandom;
      end else begin
        hi     = int'($urandom_range(0, 340)) - 20;
        mem[a] = 32'(hi * 65536 + int'($urandom_range(0, 65535)));
      end
    end
  endtask

  // Runs one block starting at the current falling edge. Returns at the
  // falling edge of cycle 67 (normal) or just after reset release (aborted).
  task automatic run_block(input int row, input int col, input int pulse_at, input int reset_at);
    logic [17:0] ea [32];
    logic [15:0] ed [32];
    int exp_n;
    int got_w;
    int done_seen;
    int a;

    exp_n = 0;
    for (int p = 0; p < 32; p++) begin
      a     = (8 * row + p / 4) * 160 + 4 * col + (p % 4);
      ea[p] = 18'(a);
      ed[p] = {ref_pix(mem[64 + 2 * p]), ref_pix(mem[64 + 2 * p + 1])};
      if (reset_at < 0 || 3 + 2 * p < reset_at) exp_n++;
    end

    WS_start  = 1'b1;
    block_row = 5'(row);
    block_col = 6'(col);
    @(negedge CLOCK_50_I);
    WS_start  = 1'b0;
    block_row = 5'($urandom);
    block_col = 6'($urandom);
    got_w     = 0;
    done_seen = 0;

    for (int k = 0; k <= 67; k++) begin
      if (k == reset_at) begin
        Resetn = 1'b0;
        #1;
        check("rst_mid_we_n", 32'(SRAM_we_n), 32'd1);
        check("rst_mid_done", 32'(WS_done), 32'd0);
        check("rst_mid_addr", 32'(SRAM_address), 32'd0);
        check("rst_mid_data", 32'(SRAM_write_data), 32'd0);
        check("rst_mid_dp_addr", 32'(dp_address), 32'd0);
        for (int j = 0; j < 4; j++) begin
          @(negedge CLOCK_50_I);
          check("rst_hold_we_n", 32'(SRAM_we_n), 32'd1);
          check("rst_hold_done", 32'(WS_done), 32'd0);
        end
        Resetn = 1'b1;
        break;
      end
      WS_start = (k == pulse_at);
      if (k < 64) begin
        check($sformatf("dp_addr[%0d]", k), 32'(dp_address), 32'(64 + k));
      end
      if (!SRAM_we_n) begin
        if (got_w < exp_n) begin
          check($sformatf("wr_addr[%0d]", got_w), 32'(SRAM_address), 32'(ea[got_w]));
          check($sformatf("wr_data[%0d]", got_w), 32'(SRAM_write_data), 32'(ed[got_w]));
          check($sformatf("wr_cycle[%0d]", got_w), 32'(k), 32'(3 + 2 * got_w));
        end else begin
          check("extra_write", 32'(got_w + 1), 32'(exp_n));
        end
        got_w++;
      end
      if (WS_done) begin
        done_seen++;
        check("done_cycle", 32'(k), 32'd66);
      end
      if (k < 67) @(negedge CLOCK_50_I);
    end
    WS_start = 1'b0;
    check("write_count", 32'(got_w), 32'(exp_n));
    check("done_count", 32'(done_seen), (reset_at < 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    Resetn    = 1'b0;
    WS_start  = 1'b0;
    block_row = '0;
    block_col = '0;
    fill(MODE_RAND, 32'd0);

    // Reset held with start toggling.
    for (int i = 0; i < 6; i++) begin
      @(negedge CLOCK_50_I);
      WS_start = ~WS_start;
      check("rst_we_n", 32'(SRAM_we_n), 32'd1);
      check("rst_done", 32'(WS_done), 32'd0);
      check("rst_addr", 32'(SRAM_address), 32'd0);
      check("rst_data", 32'(SRAM_write_data), 32'd0);
      check("rst_dp_addr", 32'(dp_address), 32'd0);
    end
    WS_start = 1'b0;
    @(negedge CLOCK_50_I);
    Resetn = 1'b1;
    @(negedge CLOCK_50_I);

    // Ramp into block (0,0).
    fill(MODE_RAMP, 32'd0);
    run_block(0, 0, -1, -1);

    // Clip low, then clip high back-to-back (start in cycle 67).
    fill(MODE_CONST, 32'hFFFB_0000);
    run_block(2, 5, -1, -1);
    fill(MODE_CONST, 32'(300) << 16);
    run_block(11, 20, -1, -1);

    // Bottom-right corner block.
    fill(MODE_RAND, 32'd0);
    run_block(29, 39, -1, -1);

    // Half-way value: 0x0101 truncating, 0x0202 rounding.
    fill(MODE_CONST, 32'h0001_8000);
    run_block(3, 7, -1, -1);

    // Start pulse in cycle 10 must be ignored.
    fill(MODE_RAND, 32'd0);
    run_block(7, 13, 10, -1);

    // Reset in cycle 20 aborts the block, then a fresh block completes.
    fill(MODE_RAND, 32'd0);
    run_block(4, 9, 10, 20);
    fill(MODE_RAND, 32'd0);
    run_block(5, 12, -1, -1);

    // A few random blocks.
    for (int b = 0; b < 3; b++) begin
      fill(MODE_RAND, 32'd0);
      run_block(int'($urandom_range(0, 29)), int'($urandom_range(0, 39)), -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/s_block_writeback.md
# s_block_writeback

Writes back one 8x8 block of S values produced by the IDCT matrix multiplier. It reads 64 signed 32-bit S accumulations from the embedded dual-port RAM, then scales, clips and packs them two pixels per 16-bit word. It then writes the 32 words into the external SRAM pixel plane at the block's raster position. It sits directly downstream of the S computation and is the last stage of the per-block IDCT loop.

## Interface
- S_BASE, 7'd64: DPRAM address of S[0][0]; S[r][c] is at S_BASE + 8r + c.
- Y_BASE, 18'd0: SRAM word address of pixel (0,0) of the target plane.
- WORDS_PER_ROW, 160: SRAM words per image row (2 pixels/word).
- SHIFT, 16: arithmetic right shift applied to each S value before clipping.

- CLOCK_50_I  in  1  single clock for the block.
- Resetn  in  1  asynchronous, active-low reset.
- WS_start  in  1  one-cycle start pulse; honoured only in IDLE.
- WS_done  out  1  one-cycle pulse after the last SRAM write.
- block_row  in  5  block row index, 0..29; latched on an accepted start.
- block_col  in  6  block column index, 0..39; latched on an accepted start.
- dp_address  out  7  DPRAM read address; read latency is 1 cycle.
- dp_read_data  in  32  DPRAM read data, signed two's complement.
- SRAM_address  out  18  SRAM word address (registered).
- SRAM_write_data  out  16  packed pixels {even[7:0], odd[7:0]} (registered).
- SRAM_we_n  out  1  SRAM write enable, active low (registered).

## Operation
- States: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
- IDLE: a start pulse latches block_row and block_col, clears read index n to 0 and enters RUN. A start pulse in any other state is ignored.
- RUN: dp_address = S_BASE + n and n increments every cycle, for n = 0..63. After n = 63 the block enters DRAIN.
- DRAIN: lasts 2 cycles and completes the final write.
- DONE: WS_done is high for 1 cycle, then the block returns to IDLE.
- Pixel conversion: v = dp_read_data >>> SHIFT, evaluated on the full 32 bits with sign extension.
  - pix = 0 if v < 0.
  - pix = 255 if v > 255.
  - Otherwise pix = v[7:0].
- Even-index data (n even) is held in an 8-bit register. When the odd-index data arrives, the even and odd pixels are packed and one SRAM write is issued.
- Write ordering: pair index p = 0..31, r = p>>2, c2 = p&3.
  - SRAM_address = Y_BASE + (8*block_row + r)*WORDS_PER_ROW + 4*block_col + c2.
  - Address arithmetic is 18-bit unsigned. Overflow is not checked.
- Reset values: WS_done = 0, SRAM_we_n = 1, SRAM_address = 0, SRAM_write_data = 0, dp_address = 0. State resets to IDLE.
- Reset asserted mid-block: outputs return to their reset values immediately. No further writes occur and no WS_done is produced. The next start processes a complete block.

## Timing
- Cycle 0 is the first RUN cycle.
- dp_address = S_BASE + n in cycle n, for n = 0..63.
- Data for index n is valid in cycle n+1. The write for odd n is registered into cycle n+2.
- SRAM_we_n is low in cycles 3, 5, ..., 65 (32 single-cycle writes). It is high in every other cycle. Address and data are stable while we_n is low.
- SRAM_address and SRAM_write_data hold their last values between writes.
- WS_done is high in cycle 66. IDLE is reached in cycle 67, where a new start is accepted.
- Total latency is 67 cycles from the first RUN cycle to IDLE.

## Configuration
- WS_ROUND_EN defined: 1 << (SHIFT-1) is added to dp_read_data in 33-bit signed arithmetic before the shift, giving round-half-up.
- WS_ROUND_EN not defined: the shift truncates toward negative infinity. There is no adder.

## Test plan
- Reset: hold Resetn low, toggle WS_start. Required: SRAM_we_n = 1, WS_done = 0, SRAM_address = 0, dp_address = 0 throughout.
- Ramp, block (0,0): DPRAM S[i] = i<<16. Required: writes to 0, 1, 2, 3, 160, 161, ..., 1123 with data 0x0001, 0x0203, ..., 0x3E3F. Exactly 32 writes. WS_done in cycle 66.
- Clip: all S = -(5<<16), then all S = 300<<16. Required: every word is 0x0000 for the first block and 0xFFFF for the second.
- Corner block (29,39): Required: first address 37276, last address 38399, 32 writes in order.
- Rounding: all S = 0x00018000. Required: words are 0x0202 with WS_ROUND_EN and 0x0101 without.
- Control: pulse WS_start at cycle 10 of a running block. Required: the pulse is ignored. Then assert Resetn low at cycle 20. Required: we_n goes high at once and no WS_done occurs. A fresh start then yields 32 writes and WS_done.
